// File: rtl/vec_addr_gen_mc_if.sv
// Bundle of the issue-side and register-file-side signals for vec_addr_gen_mc.
//   master : issue stage (drives en/abort/stall/operands, observes beats)
//   slave  : the address generator itself
// Handshake: a start is taken on a rising clk edge when en & ready & ~abort;
// a presented beat (valid=1) is consumed on an edge where stall=0, and while
// stall=1 every beat output holds its value.
// dbg_state exposes the generator FSM state (0=IDLE, 1=RUN).
interface vec_addr_gen_mc_if #(
  parameter int NUM_CH     = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int OFF_WIDTH  = 8
);
  logic                         en;
  logic                         ready;
  logic                         abort;
  logic                         stall;
  logic [NUM_CH*ADDR_WIDTH-1:0] addr_in;
  logic [NUM_CH-1:0]            ch_en;
  logic [2:0]                   max_reg_in;
  logic [OFF_WIDTH-1:0]         max_off_in;
  logic                         whole_reg;
  logic [1:0]                   whole_nr;
  logic [NUM_CH*ADDR_WIDTH-1:0] addr_out;
  logic [OFF_WIDTH-1:0]         off_out;
  logic [NUM_CH-1:0]            ch_valid;
  logic                         valid;
  logic                         addr_start;
  logic                         addr_end;
  logic                         idle;
  logic [0:0]                   dbg_state;

  modport master (
    output en, abort, stall, addr_in, ch_en, max_reg_in, max_off_in,
           whole_reg, whole_nr,
    input  ready, addr_out, off_out, ch_valid, valid, addr_start, addr_end,
           idle, dbg_state
  );

  modport slave (
    input  en, abort, stall, addr_in, ch_en, max_reg_in, max_off_in,
           whole_reg, whole_nr,
    output ready, addr_out, off_out, ch_valid, valid, addr_start, addr_end,
           idle, dbg_state
  );
endinterface

// File: rtl/vec_addr_gen_mc.sv
// Multi-channel vector register address generator.
// Walks one (register, offset) beat sequence and presents, in lock-step, the
// register address for up to NUM_CH operand groups (e.g. vs1, vs2, vd).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : vec_addr_gen_mc_if slave modport (start/abort/stall inputs,
//              per-channel bases and enables, group limits; beat outputs
//              addr_out/off_out/ch_valid/valid/addr_start/addr_end, plus
//              ready, idle and dbg_state)
module vec_addr_gen_mc #(
  parameter int VLEN       = 16384,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int OFF_WIDTH  = 8,
  parameter int NUM_CH     = 3
) (
  input  logic                clk,
  input  logic                rst,
  vec_addr_gen_mc_if.slave    bus
);

  localparam int                   OFF_MAX   = VLEN / DATA_WIDTH - 1;
  localparam logic [OFF_WIDTH-1:0] OFF_MAX_V = OFF_WIDTH'(OFF_MAX);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]                   state_q,    state_d;
  logic                         valid_q,    valid_d;
  logic                         start_q,    start_d;
  logic                         end_q,      end_d;
  logic [2:0]                   reg_q,      reg_d;
  logic [OFF_WIDTH-1:0]         off_q,      off_d;
  logic [2:0]                   max_reg_q,  max_reg_d;
  logic [OFF_WIDTH-1:0]         max_off_q,  max_off_d;
  logic [NUM_CH*ADDR_WIDTH-1:0] base_q,     base_d;
  logic [NUM_CH-1:0]            ch_en_q,    ch_en_d;
  logic [NUM_CH*ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [NUM_CH-1:0]            ch_valid_q, ch_valid_d;

  logic                 ready;
  logic                 accept;
  logic                 consume;
  logic [2:0]           nxt_reg;
  logic [OFF_WIDTH-1:0] nxt_off;

  always_comb begin
    // Ready also while the final beat is leaving, so ops chain without a bubble.
    ready   = (state_q == S_IDLE) | (valid_q & end_q & ~bus.stall);
    accept  = bus.en & ready & ~bus.abort;
    consume = valid_q & ~bus.stall;

    if (off_q == max_off_q) begin
      nxt_off = '0;
      nxt_reg = reg_q + 3'd1;
    end else begin
      nxt_off = off_q + OFF_WIDTH'(1);
      nxt_reg = reg_q;
    end

    state_d   = state_q;
    valid_d   = valid_q;
    start_d   = start_q;
    end_d     = end_q;
    reg_d     = reg_q;
    off_d     = off_q;
    max_reg_d = max_reg_q;
    max_off_d = max_off_q;
    base_d    = base_q;
    ch_en_d   = ch_en_q;

    if (bus.abort || (consume && end_q && !accept)) begin
      // Abort wins over en; finishing the last beat without a follow-on op
      // also returns to idle.
      state_d = S_IDLE;
      valid_d = 1'b0;
      start_d = 1'b0;
      end_d   = 1'b0;
      reg_d   = '0;
      off_d   = '0;
    end else if (accept) begin
      state_d   = S_RUN;
      valid_d   = 1'b1;
      start_d   = 1'b1;
      reg_d     = '0;
      off_d     = '0;
      base_d    = bus.addr_in;
      ch_en_d   = bus.ch_en;
      max_reg_d = bus.whole_reg ? 3'((4'd1 << bus.whole_nr) - 4'd1) : bus.max_reg_in;
      max_off_d = bus.whole_reg ? OFF_MAX_V : bus.max_off_in;
      end_d     = (max_reg_d == 3'd0) && (max_off_d == '0);
    end else if (consume) begin
      start_d = 1'b0;
      reg_d   = nxt_reg;
      off_d   = nxt_off;
      end_d   = (nxt_reg == max_reg_q) && (nxt_off == max_off_q);
    end

    // Addresses follow the next beat position; held naturally while stalled.
    for (int c = 0; c < NUM_CH; c++) begin
      if (valid_d && ch_en_d[c]) begin
        addr_d[c*ADDR_WIDTH +: ADDR_WIDTH] =
          base_d[c*ADDR_WIDTH +: ADDR_WIDTH] + ADDR_WIDTH'(reg_d);
      end else begin
        addr_d[c*ADDR_WIDTH +: ADDR_WIDTH] = '0;
      end
    end
    ch_valid_d = valid_d ? ch_en_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      reg_q      <= '0;
      off_q      <= '0;
      max_reg_q  <= '0;
      max_off_q  <= '0;
      base_q     <= '0;
      ch_en_q    <= '0;
      addr_q     <= '0;
      ch_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      end_q      <= end_d;
      reg_q      <= reg_d;
      off_q      <= off_d;
      max_reg_q  <= max_reg_d;
      max_off_q  <= max_off_d;
      base_q     <= base_d;
      ch_en_q    <= ch_en_d;
      addr_q     <= addr_d;
      ch_valid_q <= ch_valid_d;
    end
  end

  assign bus.ready      = ready;
  assign bus.idle       = (state_q == S_IDLE) & ~accept;
  assign bus.valid      = valid_q;
  assign bus.addr_start = start_q;
  assign bus.addr_end   = end_q;
  assign bus.off_out    = off_q;
  assign bus.addr_out   = addr_q;
  assign bus.ch_valid   = ch_valid_q;
  assign bus.dbg_state  = state_q;

endmodule
